seq_looper: RTL

SEQ_LOOPER -- requirements
Module: seq_looper

---
 rtl/seq_looper_pkg.sv | 19 +
 rtl/seq_looper_step_timer.sv | 27 ++
 rtl/seq_looper.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seq_looper_pkg.sv
// Shared types and default sizing for the step-sequencer looper.
package seq_looper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_RECORD = 2'd2
  } state_e;

  localparam int DEF_NUM_PADS       = 16;
  localparam int DEF_NUM_STEPS      = 40;
  localparam int DEF_TICKS_PER_STEP = 11025;

  // Index width that stays legal when a count of one would give zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_looper_step_timer.sv
// Step-boundary tick generator: counts 0..TICKS_PER_STEP-1 while run is high.
module step_timer
  import seq_looper_pkg::*;
#(
  parameter int TICKS_PER_STEP = DEF_TICKS_PER_STEP
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CW = idx_width(TICKS_PER_STEP);

  logic [CW-1:0] cnt_q;

  assign tick = run && (cnt_q == CW'(TICKS_PER_STEP - 1));

  always_ff @(posedge clock) begin
    if (reset || !run || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/seq_looper.sv
// Pad-pattern loop recorder/player: records pad presses per step, replays the loop.
// state  | meaning
// IDLE   | stopped; step_idx held, timer parked at zero
// PLAY   | stepping through recorded loop, emitting patterns
// RECORD | accumulating pad presses into the current step
module seq_looper
  import seq_looper_pkg::*;
#(
  parameter int NUM_PADS       = DEF_NUM_PADS,
  parameter int NUM_STEPS      = DEF_NUM_STEPS,
  parameter int TICKS_PER_STEP = DEF_TICKS_PER_STEP
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  rec_toggle,
  input  logic                                  play_en,
  input  logic                                  overdub,
  input  logic                                  clear,
  input  logic [NUM_PADS-1:0]                   data,
  output logic [NUM_PADS-1:0]                   seq_out,
  output logic                                  step_strobe,
  output logic [idx_width(NUM_STEPS)-1:0]       step_idx,
  output logic [$clog2(NUM_STEPS+1)-1:0]        loop_len,
  output logic                                  recording,
  output logic                                  playing
);

  localparam int IW = idx_width(NUM_STEPS);
  localparam int LW = $clog2(NUM_STEPS + 1);

  state_e              state_q, state_d;
  logic [NUM_PADS-1:0] steps_q [NUM_STEPS];
  logic [NUM_PADS-1:0] hold_q;
  logic [NUM_PADS-1:0] seq_out_q;
  logic                strobe_q;
  logic [IW-1:0]       step_idx_q;
  logic [LW-1:0]       loop_len_q;
  logic                overdub_q;
  logic                first_take_q;

  logic                tick;
  logic                timer_rst;
  logic                len_wrap, cap_wrap;
  logic                rec_write, play_tick;
  logic [IW-1:0]       idx_next;

  assign len_wrap = (LW'(step_idx_q) + LW'(1)) == loop_len_q;
  assign cap_wrap = step_idx_q == IW'(NUM_STEPS - 1);

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rec_toggle)                          state_d = ST_RECORD;
          else if (play_en && loop_len_q != '0)    state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (rec_toggle)                          state_d = ST_RECORD;
          else if (!play_en)                       state_d = ST_IDLE;
        end
        ST_RECORD: begin
          if (rec_toggle)
            state_d = (play_en && loop_len_q != '0) ? ST_PLAY : ST_IDLE;
          // First take filled the last slot: the loop is now full length.
          else if (tick && first_take_q && cap_wrap)
            state_d = play_en ? ST_PLAY : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign rec_write = (state_q == ST_RECORD) && tick && !clear && !rec_toggle;
  assign play_tick = (state_q == ST_PLAY) && tick && (state_d == ST_PLAY);

  always_comb begin
    idx_next = step_idx_q + IW'(1);
    if (state_q == ST_RECORD && first_take_q) begin
      if (cap_wrap) idx_next = '0;
    end else if (len_wrap) begin
      idx_next = '0;
    end
  end

  // Every state change restarts the step timer from zero.
  assign timer_rst = reset || (state_d != state_q);

  step_timer #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_step_timer (
    .clock(clock),
    .reset(timer_rst),
    .run  (state_q != ST_IDLE),
    .tick (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < NUM_STEPS; i++) steps_q[i] <= '0;
      hold_q       <= '0;
      seq_out_q    <= '0;
      strobe_q     <= 1'b0;
      step_idx_q   <= '0;
      loop_len_q   <= '0;
      overdub_q    <= 1'b0;
      first_take_q <= 1'b0;
    end else begin
      seq_out_q <= '0;
      strobe_q  <= 1'b0;
      state_q   <= state_d;
      if (clear) begin
        for (int i = 0; i < NUM_STEPS; i++) steps_q[i] <= '0;
        hold_q     <= '0;
        loop_len_q <= '0;
      end else begin
        if (rec_write) begin
          steps_q[step_idx_q] <= overdub_q ? (steps_q[step_idx_q] | hold_q | data)
                                           : (hold_q | data);
          hold_q     <= '0;
          strobe_q   <= 1'b1;
          step_idx_q <= idx_next;
          if (first_take_q) loop_len_q <= LW'(step_idx_q) + LW'(1);
        end else if (state_q == ST_RECORD) begin
          hold_q <= hold_q | data;
        end
        if (play_tick) begin
          seq_out_q  <= steps_q[step_idx_q];
          strobe_q   <= 1'b1;
          step_idx_q <= idx_next;
        end
        if (state_d != state_q) begin
          hold_q <= '0;
          if (state_d != ST_IDLE) step_idx_q <= '0;
          if (state_d == ST_RECORD) begin
            overdub_q    <= overdub;
            first_take_q <= (loop_len_q == '0);
          end
        end
      end
    end
  end

  assign seq_out     = seq_out_q;
  assign step_strobe = strobe_q;
  assign step_idx    = step_idx_q;
  assign loop_len    = loop_len_q;
  assign recording   = (state_q == ST_RECORD);
  assign playing     = (state_q == ST_PLAY);

endmodule
